bias_bank: RTL and testbench
============================

Name: bias_bank

Overview:
- Parametrised bias store for the MLP datapath. Successor to the fixed, initial-block-only bias ROM.
- Adds a runtime load port: burst writes with an auto-incrementing pointer, driven by an FSM.
- Adds a layer/neuron-addressed read port with a request/grant handshake and fixed 1-cycle latency.
- Read output is sign-extended to accumulator width, ready to feed the MAC accumulator directly.

Parameters:
- BIAS_W, 8, signed bias width.
- ACC_W, 16, output width. Must satisfy ACC_W >= BIAS_W.
- MAX_LAYERS, 4, number of layers stored.
- MAX_NEURONS, 16, neurons per layer. Must be a power of 2.
- LAYER_AW, 3, rd_layer width. Must satisfy 2^LAYER_AW > MAX_LAYERS.
- NEURON_AW, 5, rd_neuron width. Must satisfy 2^NEURON_AW > MAX_NEURONS.
- DEPTH_AW, 6, flat address width. Must satisfy DEPTH = MAX_LAYERS*MAX_NEURONS = 2^DEPTH_AW.
- INIT_FILE, "bias_init.hex", preload image. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_start  in  1  begin load burst
- ld_base  in  DEPTH_AW  first flat address of the burst
- ld_count  in  DEPTH_AW+1  number of beats (0..DEPTH)
- ld_valid  in  1  load beat valid
- ld_data  in  BIAS_W  signed load data
- ld_ready  out  1  loader accepts a beat
- ld_busy  out  1  loader not IDLE
- ld_done  out  1  one-cycle pulse at end of burst
- rd_req  in  1  read request
- rd_layer  in  LAYER_AW  layer index
- rd_neuron  in  NEURON_AW  neuron index
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_bias/rd_err valid
- rd_bias  out  ACC_W  signed, sign-extended bias
- rd_err  out  1  out-of-range index

Behaviour:
- Reset: FSM=IDLE; ld_ready=0, ld_busy=0, ld_done=0, rd_valid=0, rd_bias=0, rd_err=0; internal pointer and remaining counter = 0.
- Memory array is not cleared by reset.
- Flat address = layer*MAX_NEURONS + neuron, i.e. {layer, neuron[log2(MAX_NEURONS)-1:0]}.
- Loader FSM, IDLE/LOAD/DONE:
  - IDLE: ld_start=1 latches ptr=ld_base and rem=ld_count. Next state is LOAD if ld_count != 0, otherwise DONE.
  - LOAD: ld_ready=1. On ld_valid&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1 (wraps DEPTH-1 -> 0), rem<=rem-1. When the beat takes rem from 1 to 0, next state is DONE.
  - LOAD: ld_valid gaps are allowed and stall the burst indefinitely.
  - DONE: ld_done=1 for exactly one cycle, then IDLE.
  - ld_start outside IDLE is ignored.
  - ld_busy = (state != IDLE).
- Read port:
  - rd_gnt = rd_req & !ld_busy. Reads are blocked for the whole burst, including DONE, so no read-during-write hazard exists.
  - A granted request produces rd_valid=1 on the next clock edge, with rd_bias = sign_extend(mem[addr]) and rd_err=0. Latency is exactly 1 cycle.
  - Back-to-back grants are allowed every cycle at full throughput.
  - Out of range (rd_layer >= MAX_LAYERS or rd_neuron >= MAX_NEURONS): rd_valid=1, rd_bias=0, rd_err=1. Memory is not accessed.
  - Cycle with no grant: rd_valid=0; rd_bias and rd_err hold their last values.
- Reset mid-burst: FSM returns to IDLE, no ld_done pulse, beats already written are retained, reads are granted from the first cycle after reset deasserts.
- Reset takes priority over ld_start and rd_req in the same cycle.

Optional Feature:
- Macro BIAS_PRELOAD_EN.
- Defined: memory is initialised from INIT_FILE via $readmemh (BIAS_W-bit two's-complement hex, one entry per flat address). Reads are valid with no load burst.
- Not defined: memory is initialised to all zeros. Biases must be written through the load port.

Test Plan:
- Reset, no preload; rd_req with layer 0, neuron 0 -> next cycle rd_valid=1, rd_bias=0x0000, rd_err=0.
- Load base 0, count 2, data 80 then -96; then read (0,0) and (0,1) back-to-back -> rd_bias 0x0050 then 0xFFA0 on consecutive cycles.
- Load base 16, count 3, ld_valid idle 2 cycles between beats; rd_req held high throughout -> rd_gnt=0 for every LOAD/DONE cycle; ld_done pulses 1 cycle after beat 3; reading (1,2) returns the third value.
- Load base 63, count 2, data 5 and 7 -> mem[63]=5, mem[0]=7; read (3,15)=0x0005, read (0,0)=0x0007.
- Read (4,0) and then (0,16) -> rd_valid=1, rd_bias=0, rd_err=1 for both. ld_count=0 -> ld_done pulses 1 cycle after ld_start, no writes.
- Reset asserted after 1 of 3 beats -> ld_busy=0 and ld_ready=0 next cycle, no ld_done; the written beat reads back; rd_gnt=1 first cycle after reset.

Source files
------------

// File: rtl/bias_bank.sv
// -----------------------------------------------------------------------------
// bias_bank
//
// Runtime-loadable bias store for the MLP datapath. Biases are written by a
// burst loader (base address + beat count, auto-incrementing pointer that
// wraps at the top of the array) and read back through a layer/neuron
// addressed port. Reads use a request/grant handshake and have a fixed
// one-cycle latency. The result is sign-extended to accumulator width so it
// can feed the MAC accumulator directly.
//
// The array starts as all zeros and biases are written through the load port.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset (array contents survive it)
//   i_ld_start   begin a load burst (only honoured while the loader is idle)
//   i_ld_base    first flat address of the burst
//   i_ld_count   number of beats, 0..DEPTH
//   i_ld_valid   load beat valid
//   i_ld_data    signed load data
//   o_ld_ready   loader accepts a beat this cycle
//   o_ld_busy    loader is not idle
//   o_ld_done    one-cycle pulse at the end of a burst
//   i_rd_req     read request
//   i_rd_layer   layer index
//   i_rd_neuron  neuron index
//   o_rd_gnt     read accepted this cycle (combinational)
//   o_rd_valid   o_rd_bias / o_rd_err valid
//   o_rd_bias    sign-extended bias (0 on an out-of-range request)
//   o_rd_err     out-of-range index on the returned read
//
// Parameter constraints: ACC_W >= BIAS_W; MAX_NEURONS a power of 2;
// 2^LAYER_AW > MAX_LAYERS; 2^NEURON_AW > MAX_NEURONS;
// MAX_LAYERS*MAX_NEURONS == 2^DEPTH_AW.
// -----------------------------------------------------------------------------
module bias_bank #(
    parameter int BIAS_W      = 8,
    parameter int ACC_W       = 16,
    parameter int MAX_LAYERS  = 4,
    parameter int MAX_NEURONS = 16,
    parameter int LAYER_AW    = 3,
    parameter int NEURON_AW   = 5,
    parameter int DEPTH_AW    = 6,
    parameter     INIT_FILE   = "bias_init.hex"
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_ld_start,
    input  logic [DEPTH_AW-1:0]   i_ld_base,
    input  logic [DEPTH_AW:0]     i_ld_count,
    input  logic                  i_ld_valid,
    input  logic [BIAS_W-1:0]     i_ld_data,
    output logic                  o_ld_ready,
    output logic                  o_ld_busy,
    output logic                  o_ld_done,

    input  logic                  i_rd_req,
    input  logic [LAYER_AW-1:0]   i_rd_layer,
    input  logic [NEURON_AW-1:0]  i_rd_neuron,
    output logic                  o_rd_gnt,
    output logic                  o_rd_valid,
    output logic [ACC_W-1:0]      o_rd_bias,
    output logic                  o_rd_err
);

    localparam int DEPTH       = 1 << DEPTH_AW;
    localparam int NIDX_W      = $clog2(MAX_NEURONS);
    localparam int LSEL_W      = DEPTH_AW - NIDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [DEPTH_AW-1:0]   r_ptr;
    logic [DEPTH_AW:0]     r_rem;

    logic [BIAS_W-1:0]     r_mem [DEPTH];

    logic                  r_rd_valid;
    logic [ACC_W-1:0]      r_rd_bias;
    logic                  r_rd_err;

    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_layer_oob;
    logic                  w_neuron_oob;
    logic [DEPTH_AW-1:0]   w_addr;

    logic [7:0]            w_unused_init;

    // Array contents are deliberately outside the reset domain, so their
    // power-up value is set here to all zeros.
    assign w_unused_init = INIT_FILE[7:0];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // Loader status is decoded straight from the state register, which makes
    // all three flags zero while reset holds the FSM in IDLE.
    assign o_ld_ready  = (r_state == S_LOAD);
    assign o_ld_busy   = (r_state != S_IDLE);
    assign o_ld_done   = (r_state == S_DONE);

    assign w_beat      = o_ld_ready & i_ld_valid;
    assign w_last_beat = w_beat & (r_rem == (DEPTH_AW+1)'(1));

    // Loader FSM. A zero-length burst goes straight to DONE so the requester
    // still sees its completion pulse. The pointer wraps naturally because
    // DEPTH is exactly 2^DEPTH_AW. ld_start is only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ld_start) begin
                        r_ptr   <= i_ld_base;
                        r_rem   <= i_ld_count;
                        r_state <= (i_ld_count != '0) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_rem <= r_rem - 1'b1;
                        if (w_last_beat) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array write port. A plain always block is used because the array also
    // receives its power-up image from an initial block. Reset suppresses a
    // beat presented in the same cycle, but never clears stored data.
    always @(posedge clk) begin
        if (!reset && w_beat) begin
            r_mem[r_ptr] <= i_ld_data;
        end
    end

    // Read addressing: the flat address is the concatenation of the low layer
    // bits and the low neuron bits. The range checks use the full index
    // widths, so the dropped high bits still flag an out-of-range request.
    assign w_layer_oob  = (32'(i_rd_layer)  >= MAX_LAYERS);
    assign w_neuron_oob = (32'(i_rd_neuron) >= MAX_NEURONS);
    assign w_addr       = {i_rd_layer[LSEL_W-1:0], i_rd_neuron[NIDX_W-1:0]};

    // Reads are refused for the whole burst (including DONE), which removes
    // any read-during-write hazard on the array.
    assign o_rd_gnt = i_rd_req & ~o_ld_busy;

    // Registered read result: exactly one cycle after a grant. Without a
    // grant only the valid flag drops; bias and error hold their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_bias  <= '0;
            r_rd_err   <= 1'b0;
        end else if (o_rd_gnt) begin
            r_rd_valid <= 1'b1;
            if (w_layer_oob || w_neuron_oob) begin
                r_rd_bias <= '0;
                r_rd_err  <= 1'b1;
            end else begin
                r_rd_bias <= ACC_W'($signed(r_mem[w_addr]));
                r_rd_err  <= 1'b0;
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_bias  = r_rd_bias;
    assign o_rd_err   = r_rd_err;

endmodule

// File: tb/tb_bias_bank.sv
// -----------------------------------------------------------------------------
// tb_bias_bank
//
// Self-checking bench for bias_bank (default build, no preload). A reference
// memory of plain integers tracks every accepted load beat; expected read
// results are computed from it with ordinary arithmetic (flat index and
// two's-complement truncation). Directed cases cover the documented scenarios,
// followed by randomized bursts and reads.
// -----------------------------------------------------------------------------
module tb_bias_bank;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ldStart;
    logic [5:0]  ldBase;
    logic [6:0]  ldCount;
    logic        ldValid;
    logic [7:0]  ldData;
    logic        ldReady;
    logic        ldBusy;
    logic        ldDone;
    logic        rdReq;
    logic [2:0]  rdLayer;
    logic [4:0]  rdNeuron;
    logic        rdGnt;
    logic        rdValid;
    logic [15:0] rdBias;
    logic        rdErr;

    int          vecCount = 0;
    int          errCount = 0;
    int          modelMem [DEPTH];
    int          burstData [DEPTH];
    logic [15:0] lastBias;
    logic        lastErr;

    bias_bank dut (
        .clk         (clk),
        .reset       (reset),
        .i_ld_start  (ldStart),
        .i_ld_base   (ldBase),
        .i_ld_count  (ldCount),
        .i_ld_valid  (ldValid),
        .i_ld_data   (ldData),
        .o_ld_ready  (ldReady),
        .o_ld_busy   (ldBusy),
        .o_ld_done   (ldDone),
        .i_rd_req    (rdReq),
        .i_rd_layer  (rdLayer),
        .i_rd_neuron (rdNeuron),
        .o_rd_gnt    (rdGnt),
        .o_rd_valid  (rdValid),
        .o_rd_bias   (rdBias),
        .o_rd_err    (rdErr)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read result from the reference memory.
    task automatic expectRead(input int layer, input int neuron,
                              output logic [15:0] expBias, output logic expErr);
        if (layer >= 4 || neuron >= 16) begin
            expBias = 16'h0000;
            expErr  = 1'b1;
        end else begin
            expBias = 16'(modelMem[layer * 16 + neuron]);
            expErr  = 1'b0;
        end
    endtask

    // One granted read; leaves rdReq high so calls can run back to back.
    task automatic applyStimulus(input int layer, input int neuron);
        logic [15:0] expBias;
        logic        expErr;
        rdReq    = 1'b1;
        rdLayer  = layer[2:0];
        rdNeuron = neuron[4:0];
        #1;
        checkOutput("rd_gnt", 32'(rdGnt), 32'd1);
        tick();
        expectRead(layer, neuron, expBias, expErr);
        checkOutput("rd_valid", 32'(rdValid), 32'd1);
        checkOutput("rd_bias", 32'(rdBias), 32'(expBias));
        checkOutput("rd_err", 32'(rdErr), 32'(expErr));
        lastBias = expBias;
        lastErr  = expErr;
    endtask

    // Cycle without a request: valid drops, data and error hold.
    task automatic readIdle();
        rdReq = 1'b0;
        tick();
        checkOutput("idle_valid", 32'(rdValid), 32'd0);
        checkOutput("idle_bias_hold", 32'(rdBias), 32'(lastBias));
        checkOutput("idle_err_hold", 32'(rdErr), 32'(lastErr));
    endtask

    // Load burst of burstData[0..count-1] starting at base. gap >= 0 inserts
    // that many idle cycles before every beat; gap < 0 picks random gaps and
    // also pulses ignored ld_start requests while busy. holdReq keeps a read
    // request asserted for the whole burst to verify it is never granted.
    task automatic loadBurst(input int base, input int count, input int gap, input bit holdReq);
        int g;
        rdReq   = 1'b0;
        ldStart = 1'b1;
        ldBase  = base[5:0];
        ldCount = count[6:0];
        tick();
        ldStart = 1'b0;
        if (holdReq) begin
            rdReq    = 1'b1;
            rdLayer  = 3'($urandom_range(0, 3));
            rdNeuron = 5'($urandom_range(0, 15));
        end
        for (int b = 0; b < count; b++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
                ldValid = 1'b0;
                if (gap < 0) begin
                    ldStart = 1'($urandom_range(0, 1));
                    ldBase  = 6'($urandom_range(0, 63));
                end
                #1;
                checkOutput("ld_ready_gap", 32'(ldReady), 32'd1);
                if (holdReq) checkOutput("rd_gnt_gap", 32'(rdGnt), 32'd0);
                tick();
                ldStart = 1'b0;
            end
            ldValid = 1'b1;
            ldData  = burstData[b][7:0];
            #1;
            checkOutput("ld_ready", 32'(ldReady), 32'd1);
            checkOutput("ld_busy", 32'(ldBusy), 32'd1);
            if (holdReq) checkOutput("rd_gnt_load", 32'(rdGnt), 32'd0);
            tick();
            modelMem[(base + b) % DEPTH] = burstData[b];
        end
        ldValid = 1'b0;
        #1;
        checkOutput("ld_done", 32'(ldDone), 32'd1);
        checkOutput("ld_ready_done", 32'(ldReady), 32'd0);
        checkOutput("ld_busy_done", 32'(ldBusy), 32'd1);
        if (holdReq) begin
            checkOutput("rd_gnt_done", 32'(rdGnt), 32'd0);
            checkOutput("rd_valid_load", 32'(rdValid), 32'd0);
        end
        tick();
        rdReq = 1'b0;
        checkOutput("ld_done_end", 32'(ldDone), 32'd0);
        checkOutput("ld_busy_end", 32'(ldBusy), 32'd0);
        if (holdReq) checkOutput("rd_valid_after", 32'(rdValid), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ldStart  = 1'b0;
        ldBase   = '0;
        ldCount  = '0;
        ldValid  = 1'b0;
        ldData   = '0;
        rdReq    = 1'b0;
        rdLayer  = '0;
        rdNeuron = '0;
        lastBias = '0;
        lastErr  = 1'b0;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ld_ready", 32'(ldReady), 32'd0);
        checkOutput("rst_ld_busy", 32'(ldBusy), 32'd0);
        checkOutput("rst_ld_done", 32'(ldDone), 32'd0);
        checkOutput("rst_rd_valid", 32'(rdValid), 32'd0);
        checkOutput("rst_rd_bias", 32'(rdBias), 32'd0);
        checkOutput("rst_rd_err", 32'(rdErr), 32'd0);
        reset = 1'b0;

        // Unloaded array reads as zero
        applyStimulus(0, 0);
        checkOutput("zero_bias00", 32'(rdBias), 32'h0000);
        readIdle();

        // Load 80, -96 at base 0 then read back to back
        burstData[0] = 80;
        burstData[1] = -96;
        loadBurst(0, 2, 0, 1'b0);
        applyStimulus(0, 0);
        checkOutput("bias_80", 32'(rdBias), 32'h0050);
        applyStimulus(0, 1);
        checkOutput("bias_m96", 32'(rdBias), 32'hFFA0);
        readIdle();

        // Base 16, three beats with 2-cycle gaps, read held throughout
        burstData[0] = 17;
        burstData[1] = -3;
        burstData[2] = -128;
        loadBurst(16, 3, 2, 1'b1);
        applyStimulus(1, 2);
        checkOutput("bias_l1n2", 32'(rdBias), 32'hFF80);
        readIdle();

        // Wrap from the top address to zero
        burstData[0] = 5;
        burstData[1] = 7;
        loadBurst(63, 2, 0, 1'b0);
        applyStimulus(3, 15);
        checkOutput("wrap_l3n15", 32'(rdBias), 32'h0005);
        applyStimulus(0, 0);
        checkOutput("wrap_l0n0", 32'(rdBias), 32'h0007);

        // Out-of-range indices
        applyStimulus(4, 0);
        checkOutput("oob_layer_err", 32'(rdErr), 32'd1);
        applyStimulus(0, 16);
        checkOutput("oob_neuron_err", 32'(rdErr), 32'd1);
        readIdle();

        // Zero-length burst: done pulse right after start, nothing written
        loadBurst(8, 0, 0, 1'b1);
        applyStimulus(0, 8);

        // Reset after one of three beats
        rdReq   = 1'b0;
        ldStart = 1'b1;
        ldBase  = 6'd40;
        ldCount = 7'd3;
        tick();
        ldStart = 1'b0;
        ldValid = 1'b1;
        ldData  = 8'h9C;
        tick();
        modelMem[40] = -100;
        reset   = 1'b1;
        ldData  = 8'h33;
        tick();
        reset   = 1'b0;
        ldValid = 1'b0;
        checkOutput("mid_rst_busy", 32'(ldBusy), 32'd0);
        checkOutput("mid_rst_ready", 32'(ldReady), 32'd0);
        checkOutput("mid_rst_done", 32'(ldDone), 32'd0);
        applyStimulus(2, 8);
        checkOutput("mid_rst_kept", 32'(rdBias), 32'hFF9C);
        applyStimulus(2, 9);
        rdReq = 1'b0;
        tick();
        checkOutput("mid_rst_no_done", 32'(ldDone), 32'd0);

        // Randomized bursts and reads
        for (int n = 0; n < 25; n++) begin
            int base;
            int count;
            base  = int'($urandom_range(0, 63));
            count = int'($urandom_range(0, 10));
            for (int b = 0; b < count; b++) begin
                burstData[b] = int'($urandom_range(0, 255)) - 128;
            end
            loadBurst(base, count, -1, 1'($urandom_range(0, 1)));
            for (int r = 0; r < 6; r++) begin
                if ($urandom_range(0, 4) == 0) begin
                    applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
                end else begin
                    applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                end
            end
            readIdle();
        end

        // Final sweep over every in-range entry
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(a / 16, a % 16);
        end
        readIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
